// File: rtl/light_pwm_driver.sv
// Registered RGB PWM for the two traffic-light LEDs; codes latched only at PWM period boundaries.
// Optional LIGHT_PWM_FADE_EN: levels step one count per period toward their target instead of jumping.
module light_pwm_driver #(
    parameter int PRESCALE      = 8,
    parameter int DUTY          = 64,
    parameter int BLINK_PERIODS = 122
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] light1,
    input  logic [2:0] light2,
    output logic       ld4_r,
    output logic       ld4_g,
    output logic       ld4_b,
    output logic       ld5_r,
    output logic       ld5_g,
    output logic       ld5_b,
    output logic       fault1,
    output logic       fault2
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [7:0] L_FULL = 8'(DUTY);
    localparam logic [7:0] L_HALF = 8'(DUTY >> 1);

    typedef struct packed {
        logic       flt;
        logic [7:0] r;
        logic [7:0] g;
    } tgt_t;

    function automatic tgt_t decode(input logic [2:0] code, input logic phase);
        tgt_t t;
        t = '0;
        case (code)
            3'b100:  t.r = L_FULL;
            3'b010:  begin t.r = L_FULL; t.g = L_HALF; end
            3'b001:  t.g = L_FULL;
            3'b000:  t = '0;
            default: begin t.flt = 1'b1; t.r = phase ? L_FULL : 8'd0; end
        endcase
        return t;
    endfunction

`ifdef LIGHT_PWM_FADE_EN
    function automatic logic [7:0] step(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt)      return cur + 8'd1;
        else if (cur > tgt) return cur - 8'd1;
        else                return cur;
    endfunction
`endif

    logic [PW-1:0] r_presc;
    logic [7:0]    r_pwm_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [7:0]    r_lvl4_r, r_lvl4_g, r_lvl5_r, r_lvl5_g;
    logic          r_fault1, r_fault2;
    logic          r_ld4_r, r_ld4_g, r_ld5_r, r_ld5_g;

    logic          w_tick;
    logic          w_boundary;
    tgt_t          w_tgt4, w_tgt5;
    logic [7:0]    w_nxt4_r, w_nxt4_g, w_nxt5_r, w_nxt5_g;

    assign w_tick     = (r_presc == PW'(PRESCALE - 1));
    assign w_boundary = w_tick && (r_pwm_cnt == 8'hFF);

    always_comb begin
        w_tgt4 = decode(light1, r_blink_phase);
        w_tgt5 = decode(light2, r_blink_phase);
`ifdef LIGHT_PWM_FADE_EN
        // Blinking fault must stay crisp, so it bypasses the ramp.
        w_nxt4_r = w_tgt4.flt ? w_tgt4.r : step(r_lvl4_r, w_tgt4.r);
        w_nxt4_g = w_tgt4.flt ? w_tgt4.g : step(r_lvl4_g, w_tgt4.g);
        w_nxt5_r = w_tgt5.flt ? w_tgt5.r : step(r_lvl5_r, w_tgt5.r);
        w_nxt5_g = w_tgt5.flt ? w_tgt5.g : step(r_lvl5_g, w_tgt5.g);
`else
        w_nxt4_r = w_tgt4.r;
        w_nxt4_g = w_tgt4.g;
        w_nxt5_r = w_tgt5.r;
        w_nxt5_g = w_tgt5.g;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick)
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_boundary) begin
            if (r_blink_cnt == BW'(BLINK_PERIODS - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl4_r <= '0;
            r_lvl4_g <= '0;
            r_lvl5_r <= '0;
            r_lvl5_g <= '0;
            r_fault1 <= 1'b0;
            r_fault2 <= 1'b0;
        end else if (w_boundary) begin
            r_lvl4_r <= w_nxt4_r;
            r_lvl4_g <= w_nxt4_g;
            r_lvl5_r <= w_nxt5_r;
            r_lvl5_g <= w_nxt5_g;
            r_fault1 <= w_tgt4.flt;
            r_fault2 <= w_tgt5.flt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld4_r <= 1'b0;
            r_ld4_g <= 1'b0;
            r_ld5_r <= 1'b0;
            r_ld5_g <= 1'b0;
        end else begin
            r_ld4_r <= (r_pwm_cnt < r_lvl4_r);
            r_ld4_g <= (r_pwm_cnt < r_lvl4_g);
            r_ld5_r <= (r_pwm_cnt < r_lvl5_r);
            r_ld5_g <= (r_pwm_cnt < r_lvl5_g);
        end
    end

    assign ld4_r  = r_ld4_r;
    assign ld4_g  = r_ld4_g;
    assign ld4_b  = 1'b0;
    assign ld5_r  = r_ld5_r;
    assign ld5_g  = r_ld5_g;
    assign ld5_b  = 1'b0;
    assign fault1 = r_fault1;
    assign fault2 = r_fault2;

endmodule
